// File: rtl/accum_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BCD_SIGNED_EN to treat bin as two's complement and report its sign.
module accum_bcd_converter #(
  parameter int unsigned N      = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  start,
  input  logic [N-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  sign
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned BW = 4 * DIGITS;

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic          state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  sreg;
  logic [BW-1:0] digits;
  logic          ovf_sticky;
  logic [BW-1:0] corr;
  logic [BW+N:0] shifted;
  logic [N-1:0]  load_val;
  logic          last;

  // Per-digit correction only; any carry reaches the next digit through the shift.
  always_comb begin
    corr = digits;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits[4*i +: 4] >= 4'd5) begin
        corr[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      end
    end
  end

  // Top bit is the one leaving the highest digit.
  assign shifted = {1'b0, corr, sreg} << 1;
  assign last    = (cnt == CW'(N - 1));
  assign busy    = (state == SHIFT);

`ifdef BCD_SIGNED_EN
  logic sign_lat;
  logic sign_q;

  assign load_val = bin[N-1] ? ({N{1'b0}} - bin) : bin;
  assign sign     = sign_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      sign_lat <= 1'b0;
      sign_q   <= 1'b0;
    end else if (state == IDLE && start) begin
      sign_lat <= bin[N-1];
    end else if (state == SHIFT && last) begin
      sign_q <= sign_lat;
    end
  end
`else
  assign load_val = bin;
  assign sign     = 1'b0;
`endif

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      digits     <= '0;
      ovf_sticky <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg       <= load_val;
            digits     <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sreg       <= shifted[N-1:0];
          digits     <= shifted[BW+N-1:N];
          ovf_sticky <= ovf_sticky | shifted[BW+N];
          cnt        <= cnt + CW'(1);
          if (last) begin
            state    <= IDLE;
            done     <= 1'b1;
            bcd      <= shifted[BW+N-1:N];
            overflow <= ovf_sticky | shifted[BW+N];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/accum_bcd_converter.md
# accum_bcd_converter

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that sits directly downstream of the N-bit accumulator. It captures the accumulator sum on a start request and produces packed decimal digits for the board's seven-segment decoders. Conversion takes one iteration per input bit. A start/busy/done handshake lets the board logic retrigger a conversion after every accumulator update.

## Interface
Parameters:
- N, 8, binary input width (≥ 2)
- DIGITS, 3, number of BCD output digits (≥ 1)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- aclr  input  1  reset, asynchronous and active-high; clears all state immediately
- start  input  1  conversion request, sampled on rising clk
- bin  input  N  binary value (accumulator sum), sampled only when start is accepted
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: new result valid
- bcd  output  4*DIGITS  packed digits, [3:0] = units; registered, held between conversions
- overflow  output  1  result did not fit in DIGITS digits; registered with bcd
- sign  output  1  sign of the converted value; registered with bcd (0 unless BCD_SIGNED_EN)

## Operation
- Reset values: busy=0, done=0, bcd=0, overflow=0, sign=0, FSM=IDLE, iteration counter=0.
- FSM states:
  - IDLE: busy=0; start=1 -> latch bin into shift register, clear scratch digits and the overflow sticky bit, counter=0 -> SHIFT.
  - SHIFT: busy=1; each cycle:
    - add 3 to every scratch digit ≥ 5;
    - shift {digits, shift register} left 1;
    - OR the bit leaving the top digit into the overflow sticky bit;
    - counter++.
  - After the N-th iteration -> IDLE; load bcd/overflow/sign, assert done for that one cycle.
- Width rules: counter width is clog2(N+1). Digit correction is 4-bit, with no carry between digits (carry propagates only via the shift).
- Overflow: on overflow, bcd holds the low DIGITS digits of the true decimal value.
- start while busy=1 is ignored, with no queueing.
- start in the cycle done=1 is accepted (FSM is in IDLE).
- bin changes after acceptance have no effect on the running conversion.
- aclr mid-conversion aborts the conversion: outputs return to reset values and no done pulse is issued.

## Timing
- Edge 0: start sampled high in IDLE; busy=1 from after edge 0.
- Edges 1..N: one iteration each. After edge N: busy=0, done=1, bcd valid.
- Latency: start edge to done = N cycles. Back-to-back throughput: one conversion per N+1 cycles.
- done is high exactly one cycle. bcd, overflow and sign change only on the edge that raises done.

## Configuration
- BCD_SIGNED_EN defined:
  - bin is two's complement.
  - At acceptance, the latched value is |bin|, and sign = bin[N-1] is captured (registered with bcd at done).
  - The most negative value converts to magnitude 2^(N-1).
- BCD_SIGNED_EN undefined:
  - bin is unsigned.
  - sign is tied to 0.
  - No negation logic is present.

## Test plan
- Reset, then start with bin=8'hFF (N=8, DIGITS=3, unsigned) -> after 8 cycles: done pulse, bcd=12'h255, overflow=0, busy=0.
- bin=0, then bin=8'h80 back-to-back (start in the done cycle) -> bcd=12'h000, then 12'h128 exactly 9 cycles later; each done is 1 cycle wide.
- DIGITS=2, bin=8'hFF -> bcd=8'h55, overflow=1; then bin=8'd99 -> bcd=8'h99, overflow=0.
- start pulsed every cycle during a conversion, with bin changed mid-run -> single result matching the first latched value; busy stays high throughout.
- aclr asserted at iteration 4 (mid-clock, asynchronous) -> busy/done/bcd/overflow=0 immediately; no done pulse; the next start converts normally.
- BCD_SIGNED_EN: bin=8'h80 -> sign=1, bcd=12'h128; bin=8'hFF -> sign=1, bcd=12'h001; bin=8'h7F -> sign=0, bcd=12'h127.
